// File: rtl/dvs_ravens_pkg.sv
// Shared DVS sensor sizing, system clock period and AER word packing.
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS = 9;
  localparam int DVS_Y_ADDR_BITS = 8;
  localparam int CLK_PERIOD_NS   = 10;
  localparam int AER_BITS        = 10;

  typedef enum logic {
    PH_Y = 1'b0,
    PH_X = 1'b1
  } aer_phase_e;

  function automatic logic [AER_BITS-1:0] aer_y_word(
    input logic [DVS_Y_ADDR_BITS-1:0] y
  );
    return AER_BITS'(y);
  endfunction

  // Column in the upper bits, polarity in bit 0.
  function automatic logic [AER_BITS-1:0] aer_x_word(
    input logic [DVS_X_ADDR_BITS-1:0] x,
    input logic                       pol
  );
    return AER_BITS'({x, pol});
  endfunction

endpackage

// File: rtl/dvs_aer_transmitter.sv
// Word-serial AER transmitter: optional Y word then X word per event,
// four-phase req/ack handshake against a synchronized acknowledge.
module dvs_aer_transmitter
  import dvs_ravens_pkg::*;
#(
  parameter int SETUP_NS           = 50,
  parameter int ACK_TIMEOUT_CYCLES = 0,
  parameter int ALWAYS_SEND_Y      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DVS_X_ADDR_BITS-1:0] in_x,
  input  logic [DVS_Y_ADDR_BITS-1:0] in_y,
  input  logic                       in_polarity,
  output logic                       in_ready,
  input  logic                       ack,
  output logic [AER_BITS-1:0]        aer,
  output logic                       xsel,
  output logic                       req,
  output logic                       event_sent,
  output logic                       timeout_err
);

  localparam int SETUP_RAW =
    (SETUP_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
  localparam int SETUP_CYCLES = (SETUP_RAW < 1) ? 1 : SETUP_RAW;
  localparam int CNT_LIM =
    (SETUP_CYCLES > ACK_TIMEOUT_CYCLES) ?
    SETUP_CYCLES : ACK_TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(CNT_LIM + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_HI,
    S_WAIT_LO
  } state_e;

  state_e                     state_q, state_d;
  aer_phase_e                 phase_q, phase_d;
  logic [AER_BITS-1:0]        aer_q, aer_d;
  logic                       xsel_q, xsel_d;
  logic                       req_q, req_d;
  logic                       sent_q, sent_d;
  logic                       tmo_q, tmo_d;
  logic [DVS_Y_ADDR_BITS-1:0] last_y_q, last_y_d;
  logic                       last_vld_q, last_vld_d;
  logic [DVS_X_ADDR_BITS-1:0] x_q, x_d;
  logic [DVS_Y_ADDR_BITS-1:0] y_q, y_d;
  logic                       pol_q, pol_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ack_meta_q, ack_sync_q;

  logic accept;
  logic need_y;
  logic tmo_hit;

  // Hold off one cycle after event_sent so events never overlap.
  assign in_ready = (state_q == S_IDLE) && !sent_q;
  assign accept   = in_valid && in_ready;

  assign aer         = aer_q;
  assign xsel        = xsel_q;
  assign req         = req_q;
  assign event_sent  = sent_q;
  assign timeout_err = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_meta_q <= ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    aer_d      = aer_q;
    xsel_d     = xsel_q;
    req_d      = req_q;
    sent_d     = 1'b0;
    tmo_d      = tmo_q;
    last_y_d   = last_y_q;
    last_vld_d = last_vld_q;
    x_d        = x_q;
    y_d        = y_q;
    pol_d      = pol_q;
    need_y     = !last_vld_q || (in_y != last_y_q) ||
                 (ALWAYS_SEND_Y != 0);
    tmo_hit    = (ACK_TIMEOUT_CYCLES > 0) &&
                 (cnt_q >= CNT_W'(ACK_TIMEOUT_CYCLES));

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d     = in_x;
          y_d     = in_y;
          pol_d   = in_polarity;
          state_d = S_SETUP;
          if (need_y) begin
            phase_d = PH_Y;
            aer_d   = aer_y_word(in_y);
            xsel_d  = 1'b0;
          end else begin
            phase_d = PH_X;
            aer_d   = aer_x_word(in_x, in_polarity);
            xsel_d  = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          state_d = S_WAIT_HI;
          req_d   = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (ack_sync_q) begin
          state_d = S_WAIT_LO;
          req_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d    = S_IDLE;
          phase_d    = PH_Y;
          req_d      = 1'b0;
          tmo_d      = 1'b1;
          last_vld_d = 1'b0;
        end
      end
      S_WAIT_LO: begin
        if (!ack_sync_q) begin
          if (phase_q == PH_Y) begin
            last_y_d   = y_q;
            last_vld_d = 1'b1;
            phase_d    = PH_X;
            aer_d      = aer_x_word(x_q, pol_q);
            xsel_d     = 1'b1;
            state_d    = S_SETUP;
          end else begin
            sent_d  = 1'b1;
            phase_d = PH_Y;
            state_d = S_IDLE;
          end
        end else if (tmo_hit) begin
          state_d    = S_IDLE;
          phase_d    = PH_Y;
          req_d      = 1'b0;
          tmo_d      = 1'b1;
          last_vld_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared setup/timeout counter; restarts on every state change.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_Y;
      aer_q      <= '0;
      xsel_q     <= 1'b0;
      req_q      <= 1'b0;
      sent_q     <= 1'b0;
      tmo_q      <= 1'b0;
      last_y_q   <= '0;
      last_vld_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      pol_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      aer_q      <= aer_d;
      xsel_q     <= xsel_d;
      req_q      <= req_d;
      sent_q     <= sent_d;
      tmo_q      <= tmo_d;
      last_y_q   <= last_y_d;
      last_vld_q <= last_vld_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pol_q      <= pol_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dvs_aer_transmitter.sv
// Bench for dvs_aer_transmitter: directed table, corner sequences and
// randomized traffic against an event-level reference model.
module tb_dvs_aer_transmitter;
  import dvs_ravens_pkg::*;

  typedef struct {
    int          inst;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        p;
    int          nw;
    logic [10:0] w0;
    logic [10:0] w1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid [2];
  logic [8:0] in_x [2];
  logic [7:0] in_y [2];
  logic       in_pol [2];
  logic       in_ready [2];
  logic       ack [2];
  logic [9:0] aer [2];
  logic       xsel [2];
  logic       req [2];
  logic       event_sent [2];
  logic       timeout_err [2];
  logic       hold_low [2];

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  logic [10:0] cap [2][256];
  int          ncap [2];
  int          evcnt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dvs_aer_transmitter #(
    .SETUP_NS(50), .ACK_TIMEOUT_CYCLES(20), .ALWAYS_SEND_Y(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_x(in_x[0]), .in_y(in_y[0]),
    .in_polarity(in_pol[0]), .in_ready(in_ready[0]),
    .ack(ack[0]), .aer(aer[0]), .xsel(xsel[0]), .req(req[0]),
    .event_sent(event_sent[0]), .timeout_err(timeout_err[0])
  );

  dvs_aer_transmitter #(
    .SETUP_NS(50), .ACK_TIMEOUT_CYCLES(0), .ALWAYS_SEND_Y(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_x(in_x[1]), .in_y(in_y[1]),
    .in_polarity(in_pol[1]), .in_ready(in_ready[1]),
    .ack(ack[1]), .aer(aer[1]), .xsel(xsel[1]), .req(req[1]),
    .event_sent(event_sent[1]), .timeout_err(timeout_err[1])
  );

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Receiver: raise ack 3 cycles into req, drop it once req falls.
  initial begin
    int hi [2];
    for (int i = 0; i < 2; i++) begin
      hi[i] = 0;
      ack[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          ack[i] = 1'b0;
          hi[i] = 0;
        end else if (req[i]) begin
          hi[i]++;
          if (hi[i] >= 3 && !hold_low[i]) ack[i] = 1'b1;
        end else begin
          hi[i] = 0;
          ack[i] = 1'b0;
        end
      end
    end
  end

  // Event-level reference model and protocol monitor.
  initial begin
    logic [10:0] ew [2][2];
    int          en [2];
    int          eidx [2];
    bit          busy [2];
    bit          mlv [2];
    bit          accp [2];
    logic [7:0]  mly [2];
    logic [8:0]  ax [2];
    logic [7:0]  ay [2];
    logic        ap [2];
    int          loadc [2];
    logic [10:0] pw [2];
    logic        preq [2], pes [2], pto [2], pa1 [2], pa2 [2];
    logic [10:0] w;
    bit          ny;
    for (int i = 0; i < 2; i++) begin
      ncap[i] = 0; evcnt[i] = 0; en[i] = 0; eidx[i] = 0;
      busy[i] = 0; mlv[i] = 0; accp[i] = 0; mly[i] = '0;
      ax[i] = '0; ay[i] = '0; ap[i] = 1'b0; loadc[i] = 0;
      pw[i] = '0; preq[i] = 0; pes[i] = 0; pto[i] = 0;
      pa1[i] = 0; pa2[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        w = {xsel[i], aer[i]};
        if (!rst_n) begin
          busy[i] = 0; mlv[i] = 0; accp[i] = 0; en[i] = 0; eidx[i] = 0;
          pw[i] = '0; preq[i] = 0; pes[i] = 0; pto[i] = 0;
          pa1[i] = 0; pa2[i] = 0;
        end else begin
          if (accp[i]) begin
            busy[i] = 1; loadc[i] = cyc;
            ny = !mlv[i] || (ay[i] != mly[i]) || (i == 1);
            en[i] = 0; eidx[i] = 0;
            if (ny) begin
              ew[i][0] = {3'b000, ay[i]};
              en[i] = 1;
            end
            ew[i][en[i]] = {1'b1, ax[i], ap[i]};
            en[i]++;
            mly[i] = ay[i]; mlv[i] = 1;
          end
          if (timeout_err[i] && !pto[i]) begin
            busy[i] = 0; mlv[i] = 0;
          end
          chk("in_ready", int'(in_ready[i]),
              int'(!busy[i] && !event_sent[i]));
          if (w != pw[i]) begin
            chk("word stable under req/ack",
                int'(preq[i] | pa1[i] | pa2[i]), 0);
            loadc[i] = cyc;
          end
          if (req[i] && !preq[i]) begin
            chk("setup cycles", cyc - loadc[i], 5);
            chk("word expected", int'(eidx[i] < en[i]), 1);
            if (eidx[i] < en[i]) chk("word", int'(w), int'(ew[i][eidx[i]]));
            eidx[i]++;
            cap[i][ncap[i] % 256] = w;
            ncap[i]++;
          end
          if (event_sent[i]) begin
            chk("words per event", eidx[i], en[i]);
            chk("event_sent width", int'(pes[i]), 0);
            busy[i] = 0;
            evcnt[i]++;
          end
          accp[i] = in_valid[i] && in_ready[i];
          ax[i] = in_x[i]; ay[i] = in_y[i]; ap[i] = in_pol[i];
          pw[i] = w; preq[i] = req[i]; pes[i] = event_sent[i];
          pto[i] = timeout_err[i];
          pa2[i] = pa1[i]; pa1[i] = ack[i];
        end
      end
    end
  end

  task automatic send(int i, logic [8:0] x, logic [7:0] y, logic p);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b1; in_x[i] = x; in_y[i] = y; in_pol[i] = p;
    @(negedge clk);
    while (!in_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept ready", int'(in_ready[i]), 1);
    @(posedge clk);
    #1 in_valid[i] = 1'b0;
  endtask

  task automatic wait_sent(int i, output bit ok);
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (event_sent[i]) ok = 1;
    end
  endtask

  initial begin
    vec_t vt [8];
    int   base, rc, n, sel;
    int   ev0 [2];
    bit   ok, es;

    vt[0] = '{0, 9'd100, 8'd17, 1'b1, 2, 11'd17, {1'b1, 10'd201}};
    vt[1] = '{0, 9'd5,   8'd17, 1'b0, 1, {1'b1, 10'd10}, 11'd0};
    vt[2] = '{0, 9'd7,   8'd18, 1'b1, 2, 11'd18, {1'b1, 10'd15}};
    vt[3] = '{1, 9'd7,   8'd18, 1'b1, 2, 11'd18, {1'b1, 10'd15}};
    vt[4] = '{1, 9'd7,   8'd18, 1'b1, 2, 11'd18, {1'b1, 10'd15}};
    vt[5] = '{0, 9'd7,   8'd18, 1'b1, 1, {1'b1, 10'd15}, 11'd0};
    vt[6] = '{0, 9'd511, 8'd255, 1'b1, 2, 11'd255, {1'b1, 10'd1023}};
    vt[7] = '{0, 9'd0,   8'd0,  1'b0, 2, 11'd0, {1'b1, 10'd0}};

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_x[i] = '0; in_y[i] = '0;
      in_pol[i] = 1'b0; hold_low[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset in_ready", int'(in_ready[i]), 1);
      chk("reset req", int'(req[i]), 0);
      chk("reset aer", int'(aer[i]), 0);
      chk("reset xsel", int'(xsel[i]), 0);
      chk("reset event_sent", int'(event_sent[i]), 0);
      chk("reset timeout_err", int'(timeout_err[i]), 0);
    end

    for (int k = 0; k < 8; k++) begin
      base = ncap[vt[k].inst];
      send(vt[k].inst, vt[k].x, vt[k].y, vt[k].p);
      wait_sent(vt[k].inst, ok);
      chk("vec event_sent", int'(ok), 1);
      chk("vec word count", ncap[vt[k].inst] - base, vt[k].nw);
      chk("vec word0", int'(cap[vt[k].inst][base % 256]), int'(vt[k].w0));
      if (vt[k].nw > 1)
        chk("vec word1", int'(cap[vt[k].inst][(base + 1) % 256]),
            int'(vt[k].w1));
    end
    chk("no timeout yet", int'(timeout_err[0]), 0);

    hold_low[0] = 1'b1;
    send(0, 9'd3, 8'd40, 1'b0);
    n = 0;
    while (!req[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    rc = cyc; es = 0; n = 0;
    while (req[0] && n < 60) begin
      @(negedge clk);
      n++;
      es |= event_sent[0];
    end
    chk("timeout req high cycles", cyc - rc, 21);
    chk("timeout flag", int'(timeout_err[0]), 1);
    chk("timeout no event_sent", int'(es), 0);
    chk("timeout in_ready", int'(in_ready[0]), 1);
    hold_low[0] = 1'b0;
    base = ncap[0];
    send(0, 9'd3, 8'd40, 1'b0);
    wait_sent(0, ok);
    chk("post-timeout sent", int'(ok), 1);
    chk("post-timeout words", ncap[0] - base, 2);
    chk("post-timeout Y", int'(cap[0][base % 256]), 40);
    chk("post-timeout X", int'(cap[0][(base + 1) % 256]), 1030);
    chk("timeout sticky", int'(timeout_err[0]), 1);

    send(0, 9'd9, 8'd40, 1'b1);
    n = 0;
    while (!req[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req before reset", int'(req[0]), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset req", int'(req[0]), 0);
    chk("async reset in_ready", int'(in_ready[0]), 1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", int'(in_ready[0]), 1);
    chk("post-reset timeout_err", int'(timeout_err[0]), 0);
    chk("post-reset aer", int'(aer[0]), 0);
    base = ncap[0];
    send(0, 9'd9, 8'd40, 1'b1);
    wait_sent(0, ok);
    chk("post-reset sent", int'(ok), 1);
    chk("post-reset words", ncap[0] - base, 2);
    chk("post-reset Y", int'(cap[0][base % 256]), 40);
    chk("post-reset X", int'(cap[0][(base + 1) % 256]), 1043);

    for (int i = 0; i < 2; i++) ev0[i] = evcnt[i];
    repeat (2000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_x[i] = 9'($urandom_range(0, 511));
        sel = $urandom_range(0, 3);
        in_y[i] = (sel == 0) ? 8'd17 :
                  (sel == 1) ? 8'd18 : 8'($urandom_range(0, 255));
        in_pol[i] = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    n = 0;
    while (!(in_ready[0] && in_ready[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain idle", int'(in_ready[0] && in_ready[1]), 1);
    for (int i = 0; i < 2; i++)
      chk("random events", int'((evcnt[i] - ev0[i]) >= 10), 1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
